// File: rtl/fp_addsub_arbiter.sv
// Two-port round-robin front end for one shared fixed-latency FP adder.
// One operation in flight; results return tagged with the requester id.
module fp_addsub_arbiter #(
  parameter int ADDER_LATENCY = 4,
  parameter int CNT_W = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_z,
  output logic [31:0] adder_a,
  output logic [31:0] adder_b,
  input  logic [31:0] adder_z,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             id_q;
  logic             gnt_vld;
  logic             gnt_id;
  logic             in_idle;
  logic             accept;
  logic             cnt_last;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic             sel_op;

  // Grant select: a lone requester wins, contention goes round-robin
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    unique case (1'b1)
      (req0_valid && !req1_valid): begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end
      (!req0_valid && req1_valid): begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
      (req0_valid && req1_valid): begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant;
      end
      default: ;
    endcase
  end

  assign in_idle    = (state == IDLE) && !reset;
  assign accept     = in_idle && gnt_vld;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;
  assign cnt_last   = (cnt == CNT_W'(1));
  assign sel_a      = gnt_id ? req1_a : req0_a;
  assign sel_b      = gnt_id ? req1_b : req0_b;
  assign sel_op     = gnt_id ? req1_op : req0_op;
  assign resp_id    = id_q;
  assign busy       = (state != IDLE);

  // Next-state: accept -> wait out the adder -> hold result until taken
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = WAIT;
      WAIT: if (cnt_last) state_nx = DONE;
      DONE: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Operand launch, latency countdown and result capture
  always_ff @(posedge clock) begin
    if (reset) begin
      adder_a    <= '0;
      adder_b    <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      resp_z     <= '0;
      resp_valid <= 1'b0;
    end else begin
      if (accept) begin
        adder_a    <= sel_a;
        adder_b    <= {sel_b[31] ^ sel_op, sel_b[30:0]};
        id_q       <= gnt_id;
        last_grant <= gnt_id;
        cnt        <= CNT_W'(ADDER_LATENCY);
      end
      if (state == WAIT) begin
        if (cnt_last) begin
          resp_z     <= adder_z;
          resp_valid <= 1'b1;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
      if (state == DONE && resp_ready) resp_valid <= 1'b0;
    end
  end

endmodule
